// File: rtl/load_store_unit_if.sv
// Request, data-memory and write-back signal bundle for the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned WORD_ADDR_W = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [1:0]             req_size;
  logic                   req_signed;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic [4:0]             req_rd;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_wd;
  logic                   mem_write;
  logic                   mem_read;
  logic [31:0]            mem_rd;
  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic [31:0]            wb_data;
  logic                   misalign;

  // Master is the execute stage together with the data memory.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd, mem_rd,
    input  req_ready, mem_addr, mem_wd, mem_write, mem_read, wb_valid, wb_rd, wb_data, misalign
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd, mem_rd,
    output req_ready, mem_addr, mem_wd, mem_write, mem_read, wb_valid, wb_rd, wb_data, misalign
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time, sub-word stores as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned accesses with a misalign pulse).
module load_store_unit #(
  parameter int unsigned WORD_ADDR_W = 32
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StLoad, StStore, StRmwRd, StRmwWr} state_e;

  state_e                 r_state;
  logic                   r_req_ready;
  logic                   r_mem_read;
  logic                   r_mem_write;
  logic [WORD_ADDR_W-1:0] r_mem_addr;
  logic [31:0]            r_mem_wd;
  logic                   r_wb_valid;
  logic [4:0]             r_wb_rd;
  logic [31:0]            r_wb_data;
  logic                   r_misalign;
  logic [1:0]             r_size;
  logic [1:0]             r_lane;
  logic                   r_signed;
  logic [4:0]             r_rd;
  logic [15:0]            r_wdata;

  logic                   w_trap;
  logic [1:0]             w_size_eff;
  logic [1:0]             w_lane;
  logic [WORD_ADDR_W-1:0] w_word_idx;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_load_data;
  logic [31:0]            w_merged;

  assign w_word_idx = WORD_ADDR_W'({2'b00, bus.req_addr[31:2]});

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_size_eff = bus.req_size;
    w_lane     = bus.req_addr[1:0];
    w_trap     = (bus.req_size == 2'b11) ||
                 (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && (|bus.req_addr[1:0]));
  end
`else
  // Without trapping, size 11 behaves as a word and low address bits are forced aligned.
  always_comb begin
    w_trap     = 1'b0;
    w_size_eff = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    w_lane     = bus.req_addr[1:0];
    if (w_size_eff == 2'b01) begin
      w_lane[0] = 1'b0;
    end else if (w_size_eff == 2'b10) begin
      w_lane = 2'b00;
    end
  end
`endif

  assign w_byte = bus.mem_rd[{r_lane, 3'b000} +: 8];
  assign w_half = bus.mem_rd[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = bus.mem_rd;
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = bus.mem_rd;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_rd;
    if (r_size == 2'b00) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
      r_size      <= '0;
      r_lane      <= '0;
      r_signed    <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_req_ready <= 1'b1;
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_size      <= w_size_eff;
            r_lane      <= w_lane;
            r_signed    <= bus.req_signed;
            r_rd        <= bus.req_rd;
            r_wdata     <= bus.req_wdata[15:0];
            if (w_trap) begin
              r_misalign <= 1'b1;
            end else if (!bus.req_write) begin
              r_state    <= StLoad;
              r_mem_read <= 1'b1;
              r_mem_addr <= w_word_idx;
            end else if (w_size_eff == 2'b10) begin
              r_state     <= StStore;
              r_mem_write <= 1'b1;
              r_mem_addr  <= w_word_idx;
              r_mem_wd    <= bus.req_wdata;
            end else begin
              r_state    <= StRmwRd;
              r_mem_read <= 1'b1;
              r_mem_addr <= w_word_idx;
            end
          end
        end
        StLoad: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_mem_read  <= 1'b0;
          r_mem_addr  <= '0;
          r_wb_valid  <= 1'b1;
          r_wb_rd     <= r_rd;
          r_wb_data   <= w_load_data;
        end
        StRmwRd: begin
          // Merged word goes straight into the write-data register for the next cycle.
          r_state     <= StRmwWr;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_mem_wd    <= w_merged;
        end
        StStore, StRmwWr: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_mem_write <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wd    <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wd    = r_mem_wd;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign bus.misalign  = r_misalign;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed timing checks plus a random request stream
// scored against a byte-level memory model.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  load_store_unit_if #(.WORD_ADDR_W(32)) bus ();

  load_store_unit #(.WORD_ADDR_W(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Data memory seen by the DUT, and the reference memory updated at issue time.
  logic [31:0] env_mem [16];
  logic [31:0] ref_mem [16];
  assign bus.mem_rd = env_mem[bus.mem_addr[3:0]];
  always @(posedge clock) if (bus.mem_write) env_mem[bus.mem_addr[3:0]] <= bus.mem_wd;

  typedef struct packed {
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int unsigned a, input int unsigned nb,
                                             input bit sgn);
    logic [31:0] v;
    logic [31:0] mask;
    v = ref_mem[a / 4] >> (8 * (a % 4));
    if (nb == 4) return v;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = v & mask;
    if (sgn && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_store(input int unsigned a, input int unsigned nb, input logic [31:0] d);
    for (int i = 0; i < int'(nb); i++) begin
      int unsigned b;
      b = (a % 4) + i;
      ref_mem[a / 4][8 * b +: 8] = d[8 * i +: 8];
    end
  endtask

  task automatic model_apply(input bit wr, input logic [1:0] sz, input bit sgn,
                             input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    logic [1:0]  s;
    int unsigned aa;
    bit          bad;
    exp_t        e;
    s  = sz;
    aa = a;
`ifdef LSU_MISALIGN_TRAP_EN
    bad = (s == 2'd3) || ((aa % nbytes(s)) != 0);
`else
    bad = 1'b0;
    if (s == 2'd3) s = 2'd2;
    aa = aa - (aa % nbytes(s));
`endif
    if (bad) begin
      e.mis = 1'b1; e.rd = '0; e.data = '0;
      exp_q.push_back(e);
    end else if (wr) begin
      model_store(aa, nbytes(s), d);
    end else begin
      e.mis = 1'b0; e.rd = rd; e.data = model_load(aa, nbytes(s), sgn);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input bit commit);
    int n;
    n = 0;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_rd     = rd;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("req_ready_timeout", 96'(bus.req_ready), 96'd1);
    if (commit) model_apply(wr, sz, sgn, a, d, rd);
    @(negedge clock);
  endtask

  task automatic load_check(input logic [31:0] a, input logic [1:0] sz, input bit sgn,
                            input logic [4:0] rd, input logic [31:0] want, input string name);
    issue(1'b0, sz, sgn, a, 32'd0, rd, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clock);
    check(name, {bus.wb_valid, bus.wb_data}, {1'b1, want});
  endtask

  // Scoreboard monitor plus per-cycle protocol invariants.
  always @(negedge clock) begin
    if (reset_n) begin
      check("rd_wr_exclusive", 96'(bus.mem_read & bus.mem_write), 96'd0);
      check("wb_mis_exclusive", 96'(bus.wb_valid & bus.misalign), 96'd0);
      if (bus.wb_valid || bus.misalign) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {bus.misalign, bus.wb_rd, bus.wb_data}, 96'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.mis) check("sb_misalign", 96'(bus.misalign), 96'd1);
          else check("sb_load", {bus.misalign, bus.wb_rd, bus.wb_data}, {1'b0, e.rd, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_mem_port", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wd}, 96'd0);
    check("rst_wb_port", {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.misalign}, 96'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 96'(bus.req_ready), 96'd1);

    // Word store then word load at 0x08.
    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 5'd0, 1'b1);
    bus.req_valid = 1'b0;
    check("wstore_cycle", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wd},
          {1'b0, 1'b1, 32'd2, 32'hDEADBEEF});
    @(negedge clock);
    check("wstore_done", {bus.mem_write, bus.req_ready}, {1'b0, 1'b1});
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 5'd3, 1'b1);
    bus.req_valid = 1'b0;
    check("wload_read", {bus.mem_read, bus.mem_addr, bus.wb_valid}, {1'b1, 32'd2, 1'b0});
    @(negedge clock);
    check("wload_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 5'd3, 32'hDEADBEEF});

    // Byte store 0x55 at 0x09: read then merged write, ready low two cycles.
    issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h00000055, 5'd0, 1'b1);
    bus.req_valid = 1'b0;
    check("rmw_read", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.req_ready},
          {1'b1, 1'b0, 32'd2, 1'b0});
    @(negedge clock);
    check("rmw_write", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wd, bus.req_ready},
          {1'b0, 1'b1, 32'd2, 32'hDEAD55EF, 1'b0});
    @(negedge clock);
    check("rmw_done", {bus.mem_write, bus.req_ready}, {1'b0, 1'b1});

    // Restore 0xDEADBEEF and exercise lane extraction and extension.
    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 5'd0, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clock);
    load_check(32'h0B, 2'd0, 1'b1, 5'd4, 32'hFFFFFFDE, "lb_signed");
    load_check(32'h0B, 2'd0, 1'b0, 5'd5, 32'h000000DE, "lb_unsigned");
    load_check(32'h0A, 2'd1, 1'b1, 5'd6, 32'hFFFFDEAD, "lh_signed");
    load_check(32'h08, 2'd1, 1'b0, 5'd7, 32'h0000BEEF, "lh_unsigned");

    // Misaligned word load at 0x06.
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 5'd8, 1'b1);
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_pulse", {bus.misalign, bus.mem_read}, {1'b1, 1'b0});
    @(negedge clock);
    check("mis_after", {bus.misalign, bus.wb_valid, bus.mem_read}, 96'd0);
`else
    check("mis_aligned_read", {bus.mem_read, bus.mem_addr}, {1'b1, 32'd1});
    @(negedge clock);
`endif
    @(negedge clock);

    // Reset while in the read half of a read-modify-write.
    issue(1'b1, 2'd0, 1'b0, 32'h08, 32'h000000AA, 5'd0, 1'b0);
    bus.req_valid = 1'b0;
    check("rmw_rd_before_reset", 96'(bus.mem_read), 96'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wd}, 96'd0);
    check("rst_mid_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.misalign}, 96'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_mid_reset", 96'(bus.req_ready), 96'd1);
    check("mem_unchanged", 96'(env_mem[2]), 96'(ref_mem[2]));

    // Random stream with req_valid held high between requests.
    for (int k = 0; k < 150; k++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), 32'($urandom), 5'($urandom_range(0, 31)), 1'b1);
    end
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word_%0d", i), 96'(env_mem[i]),
                                       96'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage controller placed directly upstream of the word-addressed data memory. Accepts one load or store request at a time from the execute stage, converts the byte address to a word index, and drives the memory's ADDR/WD/MemWrite/MemRead/RD port. Byte and halfword stores are performed as read-modify-write; load data is lane-aligned, sign- or zero-extended, and registered for write-back.

## Interface
- WORD_ADDR_W, 32: width of mem_addr (word index = byte address >> 2, zero-extended).
- clock  in  1  rising-edge clock, shared with data memory
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rd  in  5  load destination register
- mem_addr  out  WORD_ADDR_W  to memory ADDR
- mem_wd  out  32  to memory WD
- mem_write  out  1  to memory MemWrite
- mem_read  out  1  to memory MemRead
- mem_rd  in  32  from memory RD (combinational read)
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  load destination
- wb_data  out  32  extended load data
- misalign  out  1  one-cycle pulse on rejected access

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR. Little-endian: byte lane = addr[1:0] (bits 8*lane+7:8*lane); half lane = addr[1].
- IDLE: mem_read = mem_write = 0, mem_addr = mem_wd = 0. On req_valid && req_ready, latch all req_* fields, then: load → LOAD; word store → STORE; byte/half store → RMW_RD.
- Alignment: half requires addr[0]=0, word requires addr[1:0]=0; size 11 always misaligned (see Configuration).
- LOAD: mem_read=1, mem_addr = addr>>2; extract lane, extend per req_signed (word ignores it), register into wb_data/wb_rd; wb_valid pulses next cycle; → IDLE.
- STORE: mem_write=1, mem_wd = wdata; → IDLE.
- RMW_RD: mem_read=1; capture mem_rd into merge register; → RMW_WR.
- RMW_WR: mem_write=1, mem_wd = captured word with only the addressed byte/half replaced by wdata[7:0]/[15:0]; → IDLE.
- mem_addr and mem_wd stable for the whole cycle that mem_write is high; mem_read and mem_write never high together.
- Stores never assert wb_valid.

## Timing
- Reset (async, reset_n low): state IDLE; mem_read, mem_write, mem_addr, mem_wd, wb_valid, wb_rd, wb_data, misalign = 0 immediately; req_ready = 1 from the first edge after release.
- Request accepted at edge N: load wb_valid at cycle N+2 (LOAD in N+1); word store mem_write in N+1; sub-word store mem_read in N+1, mem_write in N+2.
- req_ready low: 1 cycle per load/word store, 2 cycles per sub-word store; next request accepted the cycle the unit returns to IDLE (max throughput one load per 2 cycles).
- wb_valid and misalign are single-cycle pulses, never both high.
- Reset mid-operation: access abandoned, no wb_valid; reset in RMW_RD leaves memory unchanged; reset during RMW_WR/STORE leaves the write outcome undefined.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned or size-11 requests are accepted, generate no memory access and no wb_valid, pulse misalign in the following cycle, and return to IDLE (req_ready low 1 cycle).
- Undefined: misalign tied 0; address low bits forced to alignment (half clears bit 0, word clears bits 1:0, size 11 treated as word) and the access proceeds normally.

## Test plan
- Word store 0xDEADBEEF at 0x08, then word load 0x08, rd=3 → mem_write one cycle with mem_addr=2, mem_wd=0xDEADBEEF; wb_valid 2 cycles after load accept, wb_rd=3, wb_data=0xDEADBEEF.
- Byte store 0x55 at 0x09 over 0xDEADBEEF → mem_read then mem_write on mem_addr=2, mem_wd=0xDEAD55EF; req_ready low exactly 2 cycles.
- Loads over 0xDEADBEEF at word 2: signed byte 0x0B → 0xFFFFFFDE; unsigned byte 0x0B → 0x000000DE; signed half 0x0A → 0xFFFFDEAD; unsigned half 0x08 → 0x0000BEEF.
- Word load at 0x06 → with LSU_MISALIGN_TRAP_EN: misalign one cycle, mem_read never high, no wb_valid; without: reads mem_addr=1.
- reset_n pulsed low during RMW_RD → mem_read drops immediately, all outputs 0, memory word unchanged, req_ready=1 after release.
- req_valid held high over alternating load/store stream → accepts only in IDLE, no request dropped or duplicated, results in issue order.
